// File: rtl/dm_memory_map_pkg.sv
// Peripheral memory map and shared types for the debug-module bus arbiter.
// The address decoder and the arbiter state encoding live here.
package dm_memory_map_pkg;

  localparam logic [31:0] SRAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] SRAM_LEN   = 32'h0040_0000;
  localparam logic [31:0] DEBUG_BASE = 32'h1A11_0000;
  localparam logic [31:0] DEBUG_LEN  = 32'h0000_1000;
  localparam logic [31:0] UART_BASE  = 32'h1A33_0000;
  localparam logic [31:0] UART_LEN   = 32'h0000_0010;
  localparam logic [31:0] JD_BASE    = 32'h1A44_0000;
  localparam logic [31:0] JD_LEN     = 32'h0000_0008;

  typedef enum logic [1:0] {
    SLV_SRAM  = 2'd0,
    SLV_DEBUG = 2'd1,
    SLV_UART  = 2'd2,
    SLV_JD    = 2'd3
  } slv_idx_e;

  typedef struct packed {
    logic     hit;
    slv_idx_e idx;
  } dec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } arb_state_e;

  // Wrapping subtraction: addresses below base become huge and fail the check.
  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base,
                                    input logic [31:0] len);
    logic [31:0] off;
    off = addr - base;
    return (off < len);
  endfunction

  function automatic dec_t decode_addr(input logic [31:0] addr);
    dec_t d;
    d.hit = 1'b1;
    d.idx = SLV_SRAM;
    if (in_range(addr, SRAM_BASE, SRAM_LEN))        d.idx = SLV_SRAM;
    else if (in_range(addr, DEBUG_BASE, DEBUG_LEN)) d.idx = SLV_DEBUG;
    else if (in_range(addr, UART_BASE, UART_LEN))   d.idx = SLV_UART;
    else if (in_range(addr, JD_BASE, JD_LEN))       d.idx = SLV_JD;
    else                                            d.hit = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/dm_rr_arbiter2.sv
// Two-way round-robin winner selection; the preference flips away from
// whichever master was just granted.
module dm_rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  input  logic       i_acc_idx,
  output logic       o_vld,
  output logic       o_idx
);

  logic r_rr;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rr <= 1'b0;
    end else if (i_accept) begin
      r_rr <= ~i_acc_idx;
    end
  end

  always_comb begin
    o_vld = |i_req;
    o_idx = i_req[1];
    if (i_req == 2'b11) begin
      o_idx = r_rr;
    end
  end

endmodule

// File: rtl/dm_periph_bus_arbiter.sv
// Shares the peripheral bus between the core data port and the DM system-bus
// port; one transaction in flight, local error for unmapped or hung targets.
module dm_periph_bus_arbiter
  import dm_memory_map_pkg::*;
#(
  parameter int unsigned NrMst         = 2,
  parameter int unsigned NrSlv         = 4,
  parameter int unsigned TimeoutCycles = 255,
  parameter logic [31:0] ErrRdata      = 32'hBADC_AB1E
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NrMst-1:0]       m_req_i,
  output logic [NrMst-1:0]       m_gnt_o,
  input  logic [NrMst-1:0][31:0] m_addr_i,
  input  logic [NrMst-1:0]       m_we_i,
  input  logic [NrMst-1:0][3:0]  m_be_i,
  input  logic [NrMst-1:0][31:0] m_wdata_i,
  output logic [NrMst-1:0]       m_rvalid_o,
  output logic [NrMst-1:0][31:0] m_rdata_o,
  output logic [NrMst-1:0]       m_err_o,
  output logic [NrSlv-1:0]       s_req_o,
  input  logic [NrSlv-1:0]       s_gnt_i,
  output logic [31:0]            s_addr_o,
  output logic                   s_we_o,
  output logic [3:0]             s_be_o,
  output logic [31:0]            s_wdata_o,
  input  logic [NrSlv-1:0]       s_rvalid_i,
  input  logic [NrSlv-1:0][31:0] s_rdata_i,
  input  logic [NrSlv-1:0]       s_err_i
);

  localparam int unsigned CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

  arb_state_e      r_state, w_state_d;
  logic            r_mst, w_mst_d;
  logic [1:0]      r_slv, w_slv_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;

  logic            w_win_vld, w_win;
  logic            w_accept, w_acc_mst;
  logic            w_drive, w_drv_mst;
  logic [1:0]      w_drv_slv;
  dec_t            w_dec;

  dm_rr_arbiter2 u_rr (
    .i_clk     (clk_i),
    .i_rst_n   (rst_ni),
    .i_req     (m_req_i),
    .i_accept  (w_accept),
    .i_acc_idx (w_acc_mst),
    .o_vld     (w_win_vld),
    .o_idx     (w_win)
  );

  assign w_dec = decode_addr(m_addr_i[w_win]);

  always_comb begin
    w_state_d  = r_state;
    w_mst_d    = r_mst;
    w_slv_d    = r_slv;
    w_cnt_d    = '0;
    w_accept   = 1'b0;
    w_acc_mst  = 1'b0;
    w_drive    = 1'b0;
    w_drv_mst  = 1'b0;
    w_drv_slv  = '0;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    m_err_o    = '0;
    s_req_o    = '0;
    s_addr_o   = '0;
    s_we_o     = 1'b0;
    s_be_o     = '0;
    s_wdata_o  = '0;

    // Outputs are held quiet for as long as reset is asserted.
    if (rst_ni) begin
      unique case (r_state)
        IDLE: begin
          if (w_win_vld) begin
            w_mst_d = w_win;
            w_slv_d = w_dec.idx;
            if (w_dec.hit) begin
              w_drive   = 1'b1;
              w_drv_mst = w_win;
              w_drv_slv = w_dec.idx;
              if (s_gnt_i[w_dec.idx]) begin
                m_gnt_o[w_win] = 1'b1;
                w_accept       = 1'b1;
                w_acc_mst      = w_win;
                w_state_d      = RESP;
              end else begin
                w_state_d = ADDR;
              end
            end else begin
              m_gnt_o[w_win] = 1'b1;
              w_accept       = 1'b1;
              w_acc_mst      = w_win;
              w_state_d      = ERR;
            end
          end
        end
        ADDR: begin
          w_drive   = 1'b1;
          w_drv_mst = r_mst;
          w_drv_slv = r_slv;
          if (s_gnt_i[r_slv]) begin
            m_gnt_o[r_mst] = 1'b1;
            w_accept       = 1'b1;
            w_acc_mst      = r_mst;
            w_state_d      = RESP;
          end
        end
        RESP: begin
          if (s_rvalid_i[r_slv]) begin
            m_rvalid_o[r_mst] = 1'b1;
            m_rdata_o[r_mst]  = s_rdata_i[r_slv];
            m_err_o[r_mst]    = s_err_i[r_slv];
            w_state_d         = IDLE;
          end else if (r_cnt == CntW'(TimeoutCycles - 1)) begin
            m_rvalid_o[r_mst] = 1'b1;
            m_rdata_o[r_mst]  = ErrRdata;
            m_err_o[r_mst]    = 1'b1;
            w_state_d         = IDLE;
          end else begin
            w_cnt_d = r_cnt + CntW'(1);
          end
        end
        ERR: begin
          m_rvalid_o[r_mst] = 1'b1;
          m_rdata_o[r_mst]  = ErrRdata;
          m_err_o[r_mst]    = 1'b1;
          w_state_d         = IDLE;
        end
        default: w_state_d = IDLE;
      endcase

      if (w_drive) begin
        s_req_o[w_drv_slv] = 1'b1;
        s_addr_o           = m_addr_i[w_drv_mst];
        s_we_o             = m_we_i[w_drv_mst];
        s_be_o             = m_be_i[w_drv_mst];
        s_wdata_o          = m_wdata_i[w_drv_mst];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_mst   <= 1'b0;
      r_slv   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_mst   <= w_mst_d;
      r_slv   <= w_slv_d;
      r_cnt   <= w_cnt_d;
    end
  end

endmodule

// File: tb/tb_dm_periph_bus_arbiter.sv
// Bench for dm_periph_bus_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a transaction-level model.
module tb_dm_periph_bus_arbiter;

  localparam int          T    = 8;
  localparam logic [31:0] ERRD = 32'hBADC_AB1E;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0]       m_req, m_we, m_gnt, m_rvalid, m_err;
  logic [1:0][31:0] m_addr, m_wdata, m_rdata;
  logic [1:0][3:0]  m_be;
  logic [3:0]       s_req, s_gnt, s_rvalid, s_err, s_be;
  logic [31:0]      s_addr, s_wdata;
  logic             s_we;
  logic [3:0][31:0] s_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_periph_bus_arbiter #(
    .NrMst(2), .NrSlv(4), .TimeoutCycles(T), .ErrRdata(ERRD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_req_i(m_req), .m_gnt_o(m_gnt), .m_addr_i(m_addr), .m_we_i(m_we),
    .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rvalid_o(m_rvalid),
    .m_rdata_o(m_rdata), .m_err_o(m_err),
    .s_req_o(s_req), .s_gnt_i(s_gnt), .s_addr_o(s_addr), .s_we_o(s_we),
    .s_be_o(s_be), .s_wdata_o(s_wdata), .s_rvalid_i(s_rvalid),
    .s_rdata_i(s_rdata), .s_err_i(s_err)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  // Memory map as plain [base, base+len) intervals; -1 means unmapped.
  longint unsigned BASE[4] = '{64'h0, 64'h1A11_0000, 64'h1A33_0000, 64'h1A44_0000};
  longint unsigned LEN [4] = '{64'h40_0000, 64'h1000, 64'h10, 64'h8};

  function automatic int ref_slave(input logic [31:0] a);
    longint unsigned x;
    x = {32'h0, a};
    for (int i = 0; i < 4; i++)
      if (x >= BASE[i] && x < BASE[i] + LEN[i]) return i;
    return -1;
  endfunction

  // Transaction-level model: one outstanding transfer, described by who owns
  // it, where it goes, whether the target accepted it and how long it waited.
  bit       busy, granted, errp;
  int       owner, tgt, waited, pref;
  bit [1:0] gnt_seen;

  always @(negedge clk) begin
    logic [1:0]       eg, erv, eer;
    logic [1:0][31:0] erd;
    logic [3:0]       esr, ebe;
    logic [31:0]      ea, ew;
    logic             ewe;
    int               w, s, src;
    eg = '0; erv = '0; eer = '0; erd = '0; esr = '0; ebe = '0;
    ea = '0; ew = '0; ewe = 1'b0; src = -1;
    if (!rst_n) begin
      busy = 0; granted = 0; errp = 0; pref = 0; waited = 0; owner = 0; tgt = 0;
    end else if (!busy) begin
      if (m_req != 2'b00) begin
        w = (m_req == 2'b11) ? pref : int'(m_req[1]);
        s = ref_slave(m_addr[w]);
        owner = w;
        busy  = 1;
        if (s < 0) begin
          eg[w] = 1'b1; pref = 1 - w; errp = 1;
        end else begin
          tgt = s; src = w; granted = 0;
          if (s_gnt[s]) begin
            eg[w] = 1'b1; pref = 1 - w; granted = 1; waited = 0;
          end
        end
      end
    end else if (errp) begin
      erv[owner] = 1'b1; eer[owner] = 1'b1; erd[owner] = ERRD; busy = 0; errp = 0;
    end else if (!granted) begin
      src = owner;
      if (s_gnt[tgt]) begin
        eg[owner] = 1'b1; pref = 1 - owner; granted = 1; waited = 0;
      end
    end else if (s_rvalid[tgt]) begin
      erv[owner] = 1'b1; eer[owner] = s_err[tgt]; erd[owner] = s_rdata[tgt]; busy = 0;
    end else if (waited == T - 1) begin
      erv[owner] = 1'b1; eer[owner] = 1'b1; erd[owner] = ERRD; busy = 0;
    end else begin
      waited++;
    end
    if (src >= 0) begin
      esr[tgt] = 1'b1; ea = m_addr[src]; ew = m_wdata[src]; ewe = m_we[src]; ebe = m_be[src];
    end
    gnt_seen = m_gnt;
    chk("m_gnt", m_gnt, eg);
    chk("m_rvalid", m_rvalid, erv);
    chk("m_err", m_err, eer);
    chk("m_rdata", m_rdata, erd);
    chk("s_req", s_req, esr);
    chk("s_addr", s_addr, ea);
    chk("s_we", s_we, ewe);
    chk("s_be", s_be, ebe);
    chk("s_wdata", s_wdata, ew);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic clr();
    m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_be = '0;
    s_gnt = '0; s_rvalid = '0; s_rdata = '0; s_err = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clr(); step(); step(); rst_n = 1'b1;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 11))
      0:  return 32'($urandom_range(0, 32'h3F_FFFF));
      1:  return 32'h003F_FFFC;
      2:  return 32'h0040_0000;
      3:  return 32'h1A11_0000 + 32'($urandom_range(0, 32'hFFF));
      4:  return 32'h1A11_1000;
      5:  return 32'h1A33_0000 + 32'($urandom_range(0, 15));
      6:  return 32'h1A33_0010;
      7:  return 32'h1A44_0000 + 32'($urandom_range(0, 7));
      8:  return 32'h1A44_0008;
      9:  return 32'h2000_0000;
      10: return 32'h1A43_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic new_payload(input int m);
    m_addr[m]  = pick_addr();
    m_we[m]    = 1'($urandom_range(0, 1));
    m_be[m]    = 4'($urandom_range(0, 15));
    m_wdata[m] = $urandom;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    // Reset must silence every output even with live requests and responses.
    m_req = 2'b11; m_addr[0] = 32'h10; m_addr[1] = 32'h1A33_0004;
    s_gnt = 4'hF; s_rvalid = 4'hF;
    neg();
    chk("rst_gnt", m_gnt, 2'b00);
    chk("rst_rvalid", m_rvalid, 2'b00);
    chk("rst_sreq", s_req, 4'b0000);
    chk("rst_saddr", s_addr, 32'h0);

    // SRAM read with same-cycle grant and a two-cycle response.
    do_reset();
    m_req[0] = 1'b1; m_addr[0] = 32'h10; m_be[0] = 4'hF; s_gnt[0] = 1'b1;
    neg();
    chk("t1_gnt", m_gnt, 2'b01);
    chk("t1_sreq", s_req, 4'b0001);
    chk("t1_saddr", s_addr, 32'h10);
    step(); m_req[0] = 1'b0; s_gnt[0] = 1'b0;
    neg(); chk("t1_rv_early", m_rvalid, 2'b00);
    step(); s_rvalid[0] = 1'b1; s_rdata[0] = 32'h1234_5678;
    neg();
    chk("t1_rvalid", m_rvalid, 2'b01);
    chk("t1_rdata", m_rdata[0], 32'h1234_5678);
    chk("t1_rdata_other", m_rdata[1], 32'h0);
    chk("t1_err", m_err, 2'b00);
    step(); s_rvalid = '0;

    // Contention on UART: alternation, and no grant in the response cycle.
    do_reset();
    m_req = 2'b11; m_addr[0] = 32'h1A33_0004; m_addr[1] = 32'h1A33_0004; s_gnt[2] = 1'b1;
    neg(); chk("t2_gnt_a", m_gnt, 2'b01);
    step(); m_req[0] = 1'b0; s_rvalid[2] = 1'b1; s_rdata[2] = 32'hA0;
    neg(); chk("t2_rv_a", m_rvalid, 2'b01); chk("t2_gnt_hold", m_gnt, 2'b00);
    step(); s_rvalid[2] = 1'b0;
    neg(); chk("t2_gnt_b", m_gnt, 2'b10);
    step(); m_req[1] = 1'b0; s_rvalid[2] = 1'b1;
    neg(); chk("t2_rv_b", m_rvalid, 2'b10);
    step(); s_rvalid[2] = 1'b0; m_req = 2'b11;
    neg(); chk("t2_gnt_c", m_gnt, 2'b01);
    step(); m_req[0] = 1'b0; s_rvalid[2] = 1'b1;
    neg();
    step(); s_rvalid[2] = 1'b0;
    neg(); chk("t2_gnt_d", m_gnt, 2'b10);
    step(); m_req = 2'b00; s_rvalid[2] = 1'b1;
    neg();
    step(); s_rvalid = '0;

    // JD write with the slave grant delayed three cycles.
    do_reset();
    m_req[1] = 1'b1; m_we[1] = 1'b1; m_addr[1] = 32'h1A44_0004;
    m_wdata[1] = 32'hDEAD_BEEF; m_be[1] = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) s_gnt[3] = 1'b1;
      neg();
      chk("t3_sreq", s_req, 4'b1000);
      chk("t3_saddr", s_addr, 32'h1A44_0004);
      chk("t3_swdata", s_wdata, 32'hDEAD_BEEF);
      chk("t3_swe", s_we, 1'b1);
      chk("t3_gnt", m_gnt, (i == 3) ? 2'b10 : 2'b00);
      step();
    end
    m_req[1] = 1'b0; s_gnt[3] = 1'b0; s_rvalid[3] = 1'b1; s_rdata[3] = 32'h0000_0077;
    neg(); chk("t3_rvalid", m_rvalid, 2'b10); chk("t3_rdata", m_rdata[1], 32'h77);
    step(); s_rvalid = '0;

    // Unmapped address gets an immediate grant and a local error.
    do_reset();
    m_req[0] = 1'b1; m_addr[0] = 32'h2000_0000; s_gnt = 4'hF;
    neg(); chk("t4_gnt", m_gnt, 2'b01); chk("t4_sreq", s_req, 4'b0000); chk("t4_saddr", s_addr, 32'h0);
    step(); m_req[0] = 1'b0; s_gnt = '0;
    neg();
    chk("t4_rvalid", m_rvalid, 2'b01);
    chk("t4_err", m_err, 2'b01);
    chk("t4_rdata", m_rdata[0], ERRD);
    step();

    // DEBUG target grants then hangs; timeout, late rvalid dropped, recovery.
    do_reset();
    m_req[0] = 1'b1; m_addr[0] = 32'h1A11_0000; s_gnt[1] = 1'b1;
    neg(); chk("t5_gnt", m_gnt, 2'b01);
    step(); m_req[0] = 1'b0; s_gnt[1] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      neg();
      chk("t5_rvalid", m_rvalid, (i == 8) ? 2'b01 : 2'b00);
      if (i == 8) begin
        chk("t5_err", m_err, 2'b01);
        chk("t5_rdata", m_rdata[0], ERRD);
      end
      step();
    end
    s_rvalid[1] = 1'b1; s_rdata[1] = 32'h5555_5555;
    neg(); chk("t5_late_drop", m_rvalid, 2'b00);
    step(); s_rvalid[1] = 1'b0; m_req[0] = 1'b1; s_gnt[1] = 1'b1;
    neg(); chk("t5_gnt2", m_gnt, 2'b01);
    step(); m_req[0] = 1'b0; s_gnt[1] = 1'b0; s_rvalid[1] = 1'b1; s_rdata[1] = 32'hCAFE_0001;
    neg();
    chk("t5_rvalid2", m_rvalid, 2'b01);
    chk("t5_rdata2", m_rdata[0], 32'hCAFE_0001);
    chk("t5_err2", m_err, 2'b00);
    step(); s_rvalid = '0;

    // Reset while waiting for a response discards it.
    do_reset();
    m_req[0] = 1'b1; m_addr[0] = 32'h100; s_gnt[0] = 1'b1;
    neg(); chk("t6_gnt", m_gnt, 2'b01);
    step(); m_req[0] = 1'b0; s_gnt[0] = 1'b0; rst_n = 1'b0; s_rvalid[0] = 1'b1; s_rdata[0] = 32'h1;
    neg(); chk("t6_rst_rvalid", m_rvalid, 2'b00); chk("t6_rst_rdata", m_rdata, 64'h0);
    step(); rst_n = 1'b1;
    neg(); chk("t6_post_rvalid", m_rvalid, 2'b00); chk("t6_post_sreq", s_req, 4'b0000);
    step(); s_rvalid = '0;

    // Randomized OBI traffic: masters hold requests until granted.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (m_req[m] && gnt_seen[m]) begin
          m_req[m] = 1'($urandom_range(0, 1));
          if (m_req[m]) new_payload(m);
        end else if (!m_req[m] && $urandom_range(0, 2) == 0) begin
          m_req[m] = 1'b1;
          new_payload(m);
        end
      end
      s_gnt    = 4'($urandom_range(0, 15));
      s_rvalid = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      s_err    = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      for (int s = 0; s < 4; s++) s_rdata[s] = $urandom;
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
